// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: data-memory wait states with timeout, load-use
// bubbles and MEM-stage redirects, resolved combinationally with a fixed priority.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 64  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd_addr,
  input  logic        mem_valid,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic        mem_branch,
  input  logic        mem_flush,
  input  logic [31:0] mem_pc_branch,
  input  logic [31:0] mem_pc_flush,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        dmem_err,
  output logic [15:0] stall_cnt,
  output logic [0:0]  dbg_state_o
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;
  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic memop;
  logic timeout_hit;
  logic mem_stall;
  logic redirect;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic out_en;

  assign memop       = mem_valid & (mem_mem_read | mem_mem_write);
  assign timeout_hit = (state_q == ST_MEM_WAIT) && !dmem_ack && (wait_cnt_q == WAIT_LAST);

  // The abort cycle of a timeout releases the pipeline, exactly like an ack cycle.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      ST_RUN:      mem_stall = memop & ~dmem_ack;
      ST_MEM_WAIT: mem_stall = ~dmem_ack & ~timeout_hit;
      default:     mem_stall = 1'b0;
    endcase
  end

  assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use = ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) && (rs1_hit || rs2_hit);
  assign redirect = mem_valid & (mem_branch | mem_flush);

  // Outputs read 0 while reset is held, even though the inputs may be live.
  assign out_en = ~rst_;

  always_comb begin
    dmem_req     = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = 32'h0;
    if (out_en) begin
      dmem_req = (state_q == ST_MEM_WAIT) ? 1'b1 : memop;
      if (mem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (redirect) begin
        pc_redirect  = 1'b1;
        pc_target    = mem_branch ? mem_pc_branch : mem_pc_flush;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_RUN: begin
        if (memop && !dmem_ack) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          state_d = ST_RUN;
        end else if (timeout_hit) begin
          state_d = ST_RUN;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dmem_err    = err_q;
  assign stall_cnt   = stall_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: the driver pushes a hand-computed expected output
// vector per cycle; a negedge monitor pops and compares it against the live outputs.
module tb_pipeline_ctrl;

  localparam int W = 60;

  // {dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
  //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect}
  localparam logic [9:0] C_NONE   = 10'b0000000000;
  localparam logic [9:0] C_LU     = 10'b0110001000;
  localparam logic [9:0] C_MSTALL = 10'b1111100010;
  localparam logic [9:0] C_REQ    = 10'b1000000000;
  localparam logic [9:0] C_REDIR  = 10'b0000011101;

  logic        clk;
  logic        rst_;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_valid, ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        mem_valid, mem_mem_read, mem_mem_write;
  logic        mem_branch, mem_flush;
  logic [31:0] mem_pc_branch, mem_pc_flush;
  logic        dmem_ack;
  logic        dmem_req;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        dmem_err;
  logic [15:0] stall_cnt;
  logic [0:0]  dbg_state_o;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;
  logic [W-1:0] act;

  pipeline_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_(rst_),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_branch(mem_branch), .mem_flush(mem_flush),
    .mem_pc_branch(mem_pc_branch), .mem_pc_flush(mem_pc_flush),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .dmem_err(dmem_err), .stall_cnt(stall_cnt), .dbg_state_o(dbg_state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act = {dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect,
                pc_target, dmem_err, stall_cnt, dbg_state_o};

  function automatic logic [W-1:0] mk(input logic [9:0] ctl, input logic [31:0] tgt,
                                      input logic err, input logic [15:0] sc,
                                      input logic st);
    return {ctl, tgt, err, sc, st};
  endfunction

  // Driver tasks
  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd_addr = 5'd0;
    mem_valid = 1'b0; mem_mem_read = 1'b0; mem_mem_write = 1'b0;
    mem_branch = 1'b0; mem_flush = 1'b0;
    mem_pc_branch = 32'h0; mem_pc_flush = 32'h0; dmem_ack = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_vec(input string nm, input logic [W-1:0] e);
    name_q.push_back(nm);
    exp_q.push_back(e);
  endtask

  task automatic load_hazard(input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = rd;
    id_rs1_addr = 5'd3; id_uses_rs1 = 1'b1;
    id_rs2_addr = rd;   id_uses_rs2 = 1'b1;
  endtask

  task automatic mem_load(input logic ack);
    mem_valid = 1'b1; mem_mem_read = 1'b1; dmem_ack = ack;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got=%h expected=%h", nm, act, e);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_ = 1'b1;
    idle();
    next_cyc();
    // Live hazard and memop while reset is held: everything must read 0.
    load_hazard(5'd10);
    mem_load(1'b0);
    expect_vec("reset", mk(C_NONE, 32'h0, 1'b0, 16'd0, 1'b0));
    next_cyc();
    rst_ = 1'b0;
    idle();
    expect_vec("reset_release", mk(C_NONE, 32'h0, 1'b0, 16'd0, 1'b0));

    next_cyc(); load_hazard(5'd10);
    expect_vec("load_use", mk(C_LU, 32'h0, 1'b0, 16'd0, 1'b0));
    next_cyc(); idle();
    expect_vec("after_load_use", mk(C_NONE, 32'h0, 1'b0, 16'd1, 1'b0));
    next_cyc(); ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd0;
    id_rs1_addr = 5'd0; id_uses_rs1 = 1'b1;
    expect_vec("rd_zero", mk(C_NONE, 32'h0, 1'b0, 16'd1, 1'b0));
    next_cyc(); idle(); ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_uses_rs1 = 1'b0; id_rs2_addr = 5'd6; id_uses_rs2 = 1'b1;
    expect_vec("rs_unused", mk(C_NONE, 32'h0, 1'b0, 16'd1, 1'b0));

    // Load acked on the fourth cycle of dmem_req.
    next_cyc(); idle(); mem_load(1'b0);
    expect_vec("mem_c0", mk(C_MSTALL, 32'h0, 1'b0, 16'd1, 1'b0));
    next_cyc();
    expect_vec("mem_c1", mk(C_MSTALL, 32'h0, 1'b0, 16'd2, 1'b1));
    next_cyc();
    expect_vec("mem_c2", mk(C_MSTALL, 32'h0, 1'b0, 16'd3, 1'b1));
    next_cyc(); dmem_ack = 1'b1;
    expect_vec("mem_ack", mk(C_REQ, 32'h0, 1'b0, 16'd4, 1'b1));
    next_cyc(); idle();
    expect_vec("mem_done", mk(C_NONE, 32'h0, 1'b0, 16'd4, 1'b0));
    next_cyc(); mem_valid = 1'b1; mem_mem_write = 1'b1; dmem_ack = 1'b1;
    expect_vec("zero_wait", mk(C_REQ, 32'h0, 1'b0, 16'd4, 1'b0));

    // Redirects, with a load-use hazard present that must be overridden.
    next_cyc(); idle(); load_hazard(5'd10);
    mem_valid = 1'b1; mem_branch = 1'b1;
    mem_pc_branch = 32'h100; mem_pc_flush = 32'h200;
    expect_vec("branch", mk(C_REDIR, 32'h100, 1'b0, 16'd4, 1'b0));
    next_cyc(); mem_branch = 1'b0; mem_flush = 1'b1;
    expect_vec("flush", mk(C_REDIR, 32'h200, 1'b0, 16'd4, 1'b0));
    next_cyc(); idle(); mem_branch = 1'b1; mem_pc_branch = 32'h100;
    expect_vec("branch_invalid", mk(C_NONE, 32'h0, 1'b0, 16'd4, 1'b0));

    // Memory stall beats redirect and load-use, then runs into the timeout.
    next_cyc(); idle(); load_hazard(5'd10); mem_load(1'b0);
    mem_branch = 1'b1; mem_pc_branch = 32'h100;
    expect_vec("priority", mk(C_MSTALL, 32'h0, 1'b0, 16'd4, 1'b0));
    next_cyc(); idle(); mem_load(1'b0);
    expect_vec("to_w0", mk(C_MSTALL, 32'h0, 1'b0, 16'd5, 1'b1));
    next_cyc();
    expect_vec("to_w1", mk(C_MSTALL, 32'h0, 1'b0, 16'd6, 1'b1));
    next_cyc();
    expect_vec("to_w2", mk(C_MSTALL, 32'h0, 1'b0, 16'd7, 1'b1));
    next_cyc();
    expect_vec("to_abort", mk(C_REQ, 32'h0, 1'b0, 16'd8, 1'b1));
    next_cyc(); idle();
    expect_vec("err_set", mk(C_NONE, 32'h0, 1'b1, 16'd8, 1'b0));
    next_cyc(); mem_valid = 1'b1; mem_mem_write = 1'b1; dmem_ack = 1'b1;
    expect_vec("err_sticky", mk(C_REQ, 32'h0, 1'b1, 16'd8, 1'b0));

    // Reset pulse in the middle of a wait with a simultaneous hazard.
    next_cyc(); idle(); mem_load(1'b0);
    expect_vec("pre_rst_c0", mk(C_MSTALL, 32'h0, 1'b1, 16'd8, 1'b0));
    next_cyc();
    expect_vec("pre_rst_c1", mk(C_MSTALL, 32'h0, 1'b1, 16'd9, 1'b1));
    next_cyc(); load_hazard(5'd10); rst_ = 1'b1;
    expect_vec("in_reset", mk(C_NONE, 32'h0, 1'b0, 16'd0, 1'b0));
    next_cyc(); rst_ = 1'b0; idle();
    expect_vec("post_reset", mk(C_NONE, 32'h0, 1'b0, 16'd0, 1'b0));
    next_cyc(); load_hazard(5'd7);
    expect_vec("load_use_again", mk(C_LU, 32'h0, 1'b0, 16'd0, 1'b0));
    next_cyc(); idle();
    expect_vec("count_again", mk(C_NONE, 32'h0, 1'b0, 16'd1, 1'b0));

    // Final report
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles spent in MEM_WAIT before abort, legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_  input  1  asynchronous, active-high reset (1 = reset).
REQ-004 id_rs1_addr, id_rs2_addr  input  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-006 ex_valid, ex_mem_read  input  1 each  EX stage holds a valid load.
REQ-007 ex_rd_addr  input  5  EX destination register.
REQ-008 mem_valid, mem_mem_read, mem_mem_write  input  1 each  MEM stage holds a valid memory op.
REQ-009 mem_branch, mem_flush  input  1 each  taken branch / jump-or-exception redirect resolved in MEM.
REQ-010 mem_pc_branch, mem_pc_flush  input  32 each  redirect targets.
REQ-011 dmem_ack  input  1  data memory completes the current request.
REQ-012 dmem_req  output  1  data memory request strobe.
REQ-013 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  output  1 each  hold the PC / pipeline register.
REQ-014 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  insert a bubble.
REQ-015 pc_redirect  output  1;  pc_target  output  32  next-PC override.
REQ-016 dmem_err  output  1  sticky timeout flag.
REQ-017 stall_cnt  output  16  saturating count of cycles with pc_stall=1.

Function
REQ-018 FSM states RUN and MEM_WAIT; memop = mem_valid & (mem_mem_read | mem_mem_write).
REQ-019 dmem_req SHALL equal memop in RUN and 1 in MEM_WAIT.
REQ-020 RUN, memop & !dmem_ack: same cycle assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush; next state MEM_WAIT, wait counter cleared to 0.
REQ-021 RUN, memop & dmem_ack: no memory stall, remain RUN (zero-wait access).
REQ-022 MEM_WAIT: same four stalls plus mem_wb_flush asserted every cycle except the cycle dmem_ack=1, in which all stalls/mem_wb_flush deassert and next state is RUN.
REQ-023 MEM_WAIT wait counter increments each cycle without ack; reaching TIMEOUT-1 without ack SHALL set dmem_err=1, drop stalls that cycle, return to RUN.
REQ-024 Load-use hazard = ex_valid & ex_mem_read & ex_rd_addr!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)); SHALL assert pc_stall, if_id_stall, id_ex_flush for that cycle (one bubble, combinational).
REQ-025 Redirect = mem_valid & (mem_branch | mem_flush): pc_redirect=1, pc_target=mem_pc_branch if mem_branch else mem_pc_flush; if_id_flush, id_ex_flush, ex_mem_flush=1; pc_target=0 when pc_redirect=0.
REQ-026 Priority: memory stall > redirect > load-use; while memory-stalled, pc_redirect, all *_flush except mem_wb_flush, and load-use outputs SHALL be 0.
REQ-027 Redirect overrides load-use: no pc_stall/if_id_stall from hazard in a redirect cycle.
REQ-028 stall_cnt increments on each rising edge where pc_stall=1, saturates at 16'hFFFF.
REQ-029 All outputs besides dmem_err, stall_cnt are combinational from state and inputs; single-cycle decision latency.

Reset
REQ-030 rst_=1 SHALL asynchronously force state RUN, wait counter 0, dmem_err 0, stall_cnt 0; reset mid-MEM_WAIT releases all stalls immediately.
REQ-031 During reset all stall/flush/redirect/dmem_req outputs SHALL read 0.

Verification
REQ-032 ex load rd=10, ID rs2=10 used -> one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; next cycle (EX no longer load) all 0; stall_cnt=1.
REQ-033 ex_rd_addr=0 load, ID rs1=0 -> no stall.
REQ-034 mem load, dmem_ack after 3 cycles -> dmem_req 4 cycles, stalls 3 cycles, deassert on ack cycle, state RUN, stall_cnt=3.
REQ-035 mem_branch=1, mem_pc_branch=32'h100, mem_pc_flush=32'h200 -> pc_redirect=1, pc_target=32'h100, three flushes; mem_flush only -> pc_target=32'h200.
REQ-036 TIMEOUT=4, no ack -> dmem_err=1 after 4 cycles, stalls drop, dmem_err stays 1 until rst_.
REQ-037 rst_ pulsed high during MEM_WAIT and simultaneous load-use -> outputs 0 immediately; after release, RUN with stall_cnt=0.
